// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared defaults and state type for the ram64 responder slice
//
// Purpose: default geometry for the 64x16 word store and the responder FSM
// state encoding. No ports.

package ram_pkg;

  localparam int RAM_WIDTH  = 16;
  localparam int RAM_DEPTH  = 64;
  localparam int RAM_ADDR_W = 6;

  // INIT: zero-fill sweep in progress; RUN: serving requests
  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } ram_state_t;

endpackage

// File: rtl/ram64_array.sv
// rtl/ram64_array.sv - DEPTH x WIDTH register array, one sync write port, one comb read port
//
// Ports:
//   CLK    in   write clock (rising edge)
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   raddr  in   read address
//   rdata  out  read data, combinational from raddr (pre-edge contents)
// Contents are not reset; the owner clears them by sweeping the write port.

module ram64_array
  import ram_pkg::*;
#(
  parameter int WIDTH  = RAM_WIDTH,
  parameter int DEPTH  = RAM_DEPTH,
  parameter int ADDR_W = RAM_ADDR_W
) (
  input  logic              CLK,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge CLK) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ram64_responder.sv
// rtl/ram64_responder.sv - valid/ready request/response front end for a 64x16 word store
//
// Ports:
//   CLK        in   single clock, rising edge
//   RST        in   asynchronous active-high reset
//   req_valid  in   request present
//   req_ready  out  request accepted this cycle
//   req_write  in   1 = write, 0 = read
//   req_addr   in   word address
//   req_data   in   write data (ignored for reads)
//   rsp_valid  out  response present
//   rsp_ready  in   initiator takes response this cycle
//   rsp_write  out  echo of req_write for the answered request
//   rsp_data   out  read data, or the written data for a write
//   init_done  out  high once the zero-fill sweep has finished

module ram64_responder
  import ram_pkg::*;
#(
  parameter int WIDTH          = RAM_WIDTH,
  parameter int DEPTH          = RAM_DEPTH,
  parameter int ADDR_W         = RAM_ADDR_W,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [WIDTH-1:0]  req_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_write,
  output logic [WIDTH-1:0]  rsp_data,
  output logic              init_done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  ram_state_t        state, state_n;
  logic [ADDR_W-1:0] ptr, ptr_n;
  logic              sweep_we;
  logic              accept;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [WIDTH-1:0]  mem_wdata;
  logic [WIDTH-1:0]  rd_data;

  // FSM state and clear pointer
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= INIT;
      ptr   <= '0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
    end
  end

  always_comb begin
    state_n  = state;
    ptr_n    = ptr;
    sweep_we = 1'b0;
    if (state == INIT) begin
      if (CLEAR_ON_RESET != 0) begin
        sweep_we = 1'b1;
        ptr_n    = ptr + 1'b1;
        if (ptr == LAST_ADDR) begin
          state_n = RUN;
        end
      end else begin
        state_n = RUN;
      end
    end
  end

  // A slot frees up in the same cycle the pending response drains, giving
  // one transaction per cycle. Deliberately independent of req_valid.
  assign req_ready = (state == RUN) && (!rsp_valid || rsp_ready);
  assign accept    = req_valid && req_ready;
  assign init_done = (state == RUN);

  // Sweep and request writes never coincide: req_ready is low during INIT.
  assign mem_we    = sweep_we || (accept && req_write);
  assign mem_waddr = sweep_we ? ptr : req_addr;
  assign mem_wdata = sweep_we ? '0 : req_data;

  ram64_array #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_array (
    .CLK  (CLK),
    .we   (mem_we),
    .waddr(mem_waddr),
    .wdata(mem_wdata),
    .raddr(req_addr),
    .rdata(rd_data)
  );

  // Response register: loads on accept, clears when drained without a new
  // accept, otherwise holds so a stalled response stays stable.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rsp_valid <= 1'b0;
      rsp_write <= 1'b0;
      rsp_data  <= '0;
    end else if (accept) begin
      rsp_valid <= 1'b1;
      rsp_write <= req_write;
      rsp_data  <= req_write ? req_data : rd_data;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ram64_responder.sv
// tb/tb_ram64_responder.sv - randomized self-checking bench for ram64_responder

module tb_ram64_responder;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // instance with zero-fill sweep
  logic        rst = 1'b0;
  logic        req_valid = 1'b0, req_write = 1'b0, rsp_ready = 1'b0;
  logic [5:0]  req_addr = '0;
  logic [15:0] req_data = '0;
  logic        req_ready, rsp_valid, rsp_write, init_done;
  logic [15:0] rsp_data;

  // instance without sweep
  logic        rst1 = 1'b0;
  logic        req_valid1 = 1'b0, req_write1 = 1'b0, rsp_ready1 = 1'b0;
  logic [5:0]  req_addr1 = '0;
  logic [15:0] req_data1 = '0;
  logic        req_ready1, rsp_valid1, rsp_write1, init_done1;
  logic [15:0] rsp_data1;

  ram64_responder #(.CLEAR_ON_RESET(1)) dut (
    .CLK(clk), .RST(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_data(rsp_data), .init_done(init_done)
  );

  ram64_responder #(.CLEAR_ON_RESET(0)) dut_noclr (
    .CLK(clk), .RST(rst1),
    .req_valid(req_valid1), .req_ready(req_ready1), .req_write(req_write1),
    .req_addr(req_addr1), .req_data(req_data1),
    .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1), .rsp_write(rsp_write1),
    .rsp_data(rsp_data1), .init_done(init_done1)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Transaction-level reference: word store, sweep progress, and the single
  // outstanding response slot.
  logic [15:0] m_mem [64];
  bit          m_run;
  int          m_edges;
  bit          m_pend;
  logic [15:0] m_pdata;
  bit          m_pwrite;

  // Called at a negedge: apply inputs, compare outputs, advance model and
  // DUT by one rising edge, return at the following negedge.
  task automatic step(input bit v, input bit w, input int a, input logic [15:0] d, input bit rr);
    bit acc;
    bit exp_ready;
    req_valid = v;
    req_write = w;
    req_addr  = 6'(a);
    req_data  = d;
    rsp_ready = rr;
    #1;
    exp_ready = m_run && (!m_pend || rr);
    check("init_done", 32'(init_done), 32'(m_run));
    check("req_ready", 32'(req_ready), 32'(exp_ready));
    check("rsp_valid", 32'(rsp_valid), 32'(m_pend));
    if (m_pend) begin
      check("rsp_data", 32'(rsp_data), 32'(m_pdata));
      check("rsp_write", 32'(rsp_write), 32'(m_pwrite));
    end
    acc = v && exp_ready;
    if (!m_run) begin
      m_mem[m_edges] = 16'h0000;
      m_edges++;
      if (m_edges == 64) m_run = 1'b1;
    end else if (acc) begin
      if (w) begin
        m_mem[a] = d;
        m_pdata  = d;
      end else begin
        m_pdata = m_mem[a];
      end
      m_pwrite = w;
      m_pend   = 1'b1;
    end else if (m_pend && rr) begin
      m_pend = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // Asserted at a negedge; outputs must clear without waiting for a clock.
  task automatic do_reset();
    rst       = 1'b1;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    #1;
    m_pend  = 1'b0;
    m_run   = 1'b0;
    m_edges = 0;
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_write", 32'(rsp_write), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    check("rst_init_done", 32'(init_done), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic sweep_cycles();
    // requests offered throughout the sweep must be ignored
    for (int i = 0; i < 64; i++) begin
      step(1'b1, 1'($urandom_range(0, 1)), int'($urandom_range(0, 63)),
           16'($urandom), 1'b1);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 64; i++) m_mem[i] = 16'hDEAD;
    @(negedge clk);
    rst1 = 1'b1;
    do_reset();
    sweep_cycles();

    // cleared words read back as zero
    step(1'b1, 1'b0, 0, 16'h0, 1'b1);
    step(1'b1, 1'b0, 37, 16'h0, 1'b1);
    step(1'b1, 1'b0, 63, 16'h0, 1'b1);
    step(1'b0, 1'b0, 0, 16'h0, 1'b1);

    // back-to-back writes then reads
    for (int i = 0; i < 64; i++) step(1'b1, 1'b1, i, 16'(i), 1'b1);
    for (int i = 0; i < 64; i++) step(1'b1, 1'b0, i, 16'h0, 1'b1);
    step(1'b0, 1'b0, 0, 16'h0, 1'b1);

    // read-after-write on consecutive cycles
    step(1'b1, 1'b1, 5, 16'hBEEF, 1'b1);
    step(1'b1, 1'b0, 5, 16'h0, 1'b1);
    step(1'b0, 1'b0, 0, 16'h0, 1'b1);

    // backpressure with a queued read
    step(1'b1, 1'b1, 9, 16'h1234, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 9, 16'h0, 1'b0);
    step(1'b1, 1'b0, 9, 16'h0, 1'b1);
    step(1'b0, 1'b0, 0, 16'h0, 1'b1);

    // randomized traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           int'($urandom_range(0, 63)), 16'($urandom),
           ($urandom_range(0, 3) != 0));
    end

    // reset with a response pending, then the sweep must wipe addr 5
    step(1'b1, 1'b1, 5, 16'hBEEF, 1'b1);
    do_reset();
    sweep_cycles();
    step(1'b1, 1'b0, 5, 16'h0, 1'b1);
    step(1'b0, 1'b0, 0, 16'h0, 1'b1);

    // no-sweep instance: ready one edge after release, addr 63 round-trips
    rst1 = 1'b0;
    #1;
    check("noclr_ready_pre", 32'(req_ready1), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("noclr_ready", 32'(req_ready1), 32'd1);
    check("noclr_init_done", 32'(init_done1), 32'd1);
    req_valid1 = 1'b1;
    req_write1 = 1'b1;
    req_addr1  = 6'd63;
    req_data1  = 16'hFFFF;
    rsp_ready1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("noclr_wr_valid", 32'(rsp_valid1), 32'd1);
    check("noclr_wr_data", 32'(rsp_data1), 32'hFFFF);
    check("noclr_wr_write", 32'(rsp_write1), 32'd1);
    req_write1 = 1'b0;
    req_data1  = 16'h0000;
    @(posedge clk);
    @(negedge clk);
    req_valid1 = 1'b0;
    check("noclr_rd_valid", 32'(rsp_valid1), 32'd1);
    check("noclr_rd_data", 32'(rsp_data1), 32'hFFFF);
    check("noclr_rd_write", 32'(rsp_write1), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("noclr_drained", 32'(rsp_valid1), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
